stack_mem_arbiter: RTL

//  Two-port round-robin arbiter and access sequencer for the shared 32x8 data memory.

---
 rtl/stack_mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stack_mem_arbiter.sv
// rtl/stack_mem_arbiter.sv - two-port round-robin arbiter and access sequencer for a shared data memory
//
// Port 0 is the instruction-fetch path and port 1 is the stack push/pop path.
// Only one memory access runs at a time. The access moves through three states:
// IDLE, then ACCESS, then DONE.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   req[1:0], we[1:0]   per-port request and write enable (bit0 = fetch, bit1 = stack)
//   addr0/1, wdata0/1   per-port address and write data
//   gnt[1:0]            one-hot owner, high through ACCESS and DONE
//   done[1:0]           one-cycle completion pulse to the owner
//   rdata               last completed read result
//   busy                high whenever the sequencer is not idle
//   mem_read/mem_write  memory strobes, driven only in ACCESS
//   mem_addr/mem_wdata  memory address and write data, driven only in ACCESS
//   mem_rdata           combinational read data from the memory
module stack_mem_arbiter #(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t            state;
    logic              win_q;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              pick;
    logic              in_access;

    // On a tie, the port that was not served last wins.
    // Otherwise the only requesting port wins.
    // last_q resets to 1, so port 0 wins the first tie.
    assign pick = (req == 2'b11) ? ~last_q : req[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            gnt     <= 2'b00;
            done    <= 2'b00;
            rdata   <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        win_q   <= pick;
                        we_q    <= we[pick];
                        addr_q  <= pick ? addr1 : addr0;
                        wdata_q <= pick ? wdata1 : wdata0;
                        cnt     <= CNT_W'(ACCESS_CYCLES - 1);
                        gnt     <= pick ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!we_q) begin
                            rdata <= mem_rdata;
                        end
                        done  <= win_q ? 2'b10 : 2'b01;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requests are not sampled here.
                    // A request still held high is sampled again in IDLE.
                    done   <= 2'b00;
                    gnt    <= 2'b00;
                    busy   <= 1'b0;
                    last_q <= win_q;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The strobes are decoded from state rather than registered.
    // An asynchronous reset during an access therefore drops them immediately.
    assign in_access = (state == ST_ACCESS);
    assign mem_read  = in_access & ~we_q;
    assign mem_write = in_access & we_q;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = in_access ? wdata_q : '0;

endmodule
